fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch reader on the program-counter interface. Takes the current PC and
//  issues word fetches to instruction memory over a req/gnt + rvalid handshake, with at
//  most 1 outstanding. Buffers returned {pc, inst} pairs in a small FIFO and hands them
//  to decode on valid/ready. Pulses pc_advance so the PC register loads pc+4.
//  redirect (branch/jump/exception) flushes all in-flight and buffered work.
// PARAMETERS
//  ADDR_W  64  PC / instruction-memory address width
//  INST_W  32  instruction word width
//  DEPTH   2   FIFO entries; power of 2, >= 2
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  reset        in   1       synchronous, active-high reset
//  pc_in        in   ADDR_W  current PC (fetch address)
//  pc_advance   out  1       1-cycle pulse: fetch of pc_in accepted; PC loads pc+4
//  redirect     in   1       flush; PC is reloaded externally in the same cycle
//  imem_req     out  1       fetch request
//  imem_addr    out  ADDR_W  {pc_in[ADDR_W-1:2],2'b00}; valid while imem_req=1
//  imem_gnt     in   1       memory accepts request this cycle
//  imem_rvalid  in   1       response valid
//  imem_rdata   in   INST_W  response instruction word
//  inst_valid   out  1       FIFO head valid
//  inst_out     out  INST_W  FIFO head instruction
//  inst_pc      out  ADDR_W  PC of FIFO head
//  inst_ready   in   1       decode consumes head when inst_valid & inst_ready
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, inst_valid=0, inst_out=0, inst_pc=0, imem_req=0,
//   pc_advance=0. Reset wins over every other input. Reset mid-WAIT abandons the request;
//   a later rvalid is ignored (IDLE).
//  FSM states:
//   IDLE:  imem_req = ~redirect & (count < DEPTH). On req&gnt: latch req_pc=pc_in,
//          pc_advance=1, go to WAIT. rvalid is ignored; assertion fires.
//   WAIT:  imem_req=0. On rvalid: push {req_pc, rdata}, go to IDLE.
//          redirect without rvalid: go to DRAIN. redirect with rvalid: drop data, go IDLE.
//   DRAIN: imem_req=0. On rvalid: discard, go IDLE. redirect here: stay in DRAIN.
//  imem_req/imem_addr/pc_advance are combinational from state, count, pc_in, gnt and
//   redirect. Once raised, req/addr stay stable until gnt (pc_in is held by the
//   PC, since pc_advance=0 until gnt).
//  Throughput: 1 instr per 2 cycles with 1-cycle memory. The next request is issued
//   the cycle after rvalid.
//  Latency: gnt at cycle t, rvalid at t+1 -> inst_valid at t+2 (registered FIFO).
//  FIFO credit: count = occupancy + (state==WAIT). A request only issues if
//   count < DEPTH, so a push never hits a full FIFO. A pop and a push in the same
//   cycle are both honoured.
//  redirect: FIFO is emptied on the next edge; inst_valid=0 the following cycle.
//   flush beats a same-cycle pop and push. No request is issued in the redirect cycle.
//  Pointers: log2(DEPTH) bits, wrapping naturally. Occupancy counter is
//   log2(DEPTH)+1 bits.
//  inst_out/inst_pc always show storage[rd_ptr]; they are don't-care when inst_valid=0.
// STRUCTURE
//  fetch_pkg: fetch_state_e {IDLE=2'd0, WAIT=2'd1, DRAIN=2'd2}; ADDR_W/INST_W defaults;
//   WORD_OFS=2'b00.
//  Sub-module fetch_fifo: DEPTH x (ADDR_W+INST_W), with push, pop, flush, count,
//   empty, head_pc, head_inst.
//  FSM, credit check and memory handshake live in fetch_unit.
// TESTING
//  1 reset; pc_in=0, gnt=1, 1-cycle mem returns 32'h00500093 -> req @c1 addr 0,
//    pc_advance @c1, inst_valid @c3 with inst 00500093, pc 0.
//  2 inst_ready=0, DEPTH=2, 2 fetches (pc 0, 4) -> imem_req held 0; one pop ->
//    req for pc 8 next cycle.
//  3 gnt low 5 cycles, pc_in=0x100 -> imem_req=1, addr=0x100 stable, pc_advance=0
//    throughout; gnt -> one pulse.
//  4 redirect in WAIT, rvalid 3 cycles later -> no push, DRAIN->IDLE, next fetch at
//    new pc_in=0x40.
//  5 redirect with rvalid in same cycle, FIFO holding 1 -> both dropped, inst_valid=0
//    next cycle, req resumes cycle after.
//  6 reset mid-WAIT, rvalid next cycle -> all outputs 0, no push, first post-reset
//    req uses pc_in.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch block.
package fetch_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int INST_W_DEF = 32;

    // Low address bits forced on every fetch so requests are word aligned
    localparam logic [1:0] WORD_OFS = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small queue of fetched {pc, inst} pairs between memory and decode.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_pc,
    input  logic [INST_W-1:0]        push_inst,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic [ADDR_W-1:0]        head_pc,
    output logic [INST_W-1:0]        head_inst
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push   = push & ~flush;
    assign do_pop    = pop & ~flush & ~empty;
    assign empty     = (count == '0);
    assign head_pc   = pc_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];

    // Pointers and occupancy; flush empties the queue and beats any push/pop
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads zero before any fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (do_push) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, buffered results to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_advance,
    input  logic              redirect,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state;
    logic [ADDR_W-1:0] req_pc;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  credit;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              stale_rsp;

    // The in-flight request reserves a slot so its response always fits
    assign credit     = fifo_count + CNT_W'(state == WAIT);
    assign imem_req   = ~reset & (state == IDLE) & ~redirect & (credit < CNT_W'(DEPTH));
    assign imem_addr  = {pc_in[ADDR_W-1:2], WORD_OFS};
    assign pc_advance = imem_req & imem_gnt;
    assign push       = (state == WAIT) & imem_rvalid & ~redirect;
    assign pop        = inst_valid & inst_ready;
    assign inst_valid = ~fifo_empty;

    fetch_fifo #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_pc   (req_pc),
        .push_inst (imem_rdata),
        .pop       (pop),
        .flush     (redirect),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .head_pc   (inst_pc),
        .head_inst (inst_out)
    );

    // Fetch FSM: issue, wait for the response, or drain one killed by redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    assert (!imem_rvalid || stale_rsp)
                        else $error("fetch_unit: rvalid with no outstanding request");
                    if (pc_advance) state <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid)   state <= IDLE;
                    else if (redirect) state <= DRAIN;
                end
                DRAIN: begin
                    if (imem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Remember a request abandoned by reset so its late response is tolerated
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state != IDLE) stale_rsp <= 1'b1;
        end else if (imem_rvalid || pc_advance) begin
            stale_rsp <= 1'b0;
        end
    end

    // Capture the granted fetch PC to tag the returning instruction
    always_ff @(posedge clk) begin
        if (pc_advance) req_pc <= pc_in;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected decode entries.
module tb_fetch_unit;

    localparam int AW = 64;
    localparam int IW = 32;
    localparam int DP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_in;
    logic          pc_advance;
    logic          redirect;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;
    logic          inst_valid;
    logic [IW-1:0] inst_out;
    logic [AW-1:0] inst_pc;
    logic          inst_ready;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
    } ent_t;

    ent_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic          exp_push = 1'b0;
    logic [AW-1:0] last_pc = '0;

    fetch_unit #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DP)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_advance  (pc_advance),
        .redirect    (redirect),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a memory response this cycle; push says whether decode should see it
    task automatic resp(input logic [IW-1:0] d, input logic push);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        exp_push    = push;
    endtask

    // Check one cycle (inputs already driven at negedge), then advance to the next negedge
    task automatic cycle(input logic e_req, input logic e_adv);
        ent_t          e;
        logic [AW-1:0] nxt_pc;
        #1;
        chk("imem_req", imem_req, e_req);
        chk("pc_advance", pc_advance, e_adv);
        if (e_req) chk("imem_addr", imem_addr, {pc_in[AW-1:2], 2'b00});
        chk("inst_valid", inst_valid, sb.size() != 0);
        if (inst_valid && inst_ready && sb.size() != 0) begin
            e = sb.pop_front();
            chk("inst_pc", inst_pc, e.pc);
            chk("inst_out", inst_out, e.inst);
        end
        nxt_pc = pc_in;
        if (e_adv) begin
            last_pc = pc_in;
            nxt_pc  = pc_in + 4;
        end
        if (reset || redirect) sb.delete();
        else if (exp_push)     sb.push_back('{last_pc, imem_rdata});
        exp_push = 1'b0;
        @(negedge clk);
        pc_in       = nxt_pc;
        imem_rvalid = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        pc_in       = '0;
        redirect    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_pc_advance", pc_advance, 1'b0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst_out", inst_out, '0);
        chk("rst_inst_pc", inst_pc, '0);

        // Test 1: basic fetch, 1-cycle memory
        reset = 1'b0; imem_gnt = 1'b1; pc_in = '0; inst_ready = 1'b1;
        cycle(1'b1, 1'b1);
        resp(32'h00500093, 1'b1);
        cycle(1'b0, 1'b0);
        imem_gnt = 1'b0;
        cycle(1'b1, 1'b0);

        // Test 2: decode stalled, FIFO fills and blocks requests
        inst_ready = 1'b0; imem_gnt = 1'b1; pc_in = '0;
        cycle(1'b1, 1'b1);
        resp(32'h11111111, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        resp(32'h22222222, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        inst_ready = 1'b1;
        cycle(1'b0, 1'b0);
        inst_ready = 1'b0;
        cycle(1'b1, 1'b1);
        resp(32'h33333333, 1'b1);
        cycle(1'b0, 1'b0);
        inst_ready = 1'b1; imem_gnt = 1'b0;
        cycle(1'b0, 1'b0);

        // Test 3: grant held off for several cycles
        pc_in = 64'h100;
        repeat (5) cycle(1'b1, 1'b0);
        imem_gnt = 1'b1;
        cycle(1'b1, 1'b1);
        imem_gnt = 1'b0;
        resp(32'h44444444, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);

        // Test 4: redirect while waiting, late response drained
        imem_gnt = 1'b1;
        cycle(1'b1, 1'b1);
        imem_gnt = 1'b0; redirect = 1'b1; pc_in = 64'h40;
        cycle(1'b0, 1'b0);
        redirect = 1'b0;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        resp(32'h55555555, 1'b0);
        cycle(1'b0, 1'b0);
        imem_gnt = 1'b1;
        cycle(1'b1, 1'b1);
        imem_gnt = 1'b0;
        resp(32'h66666666, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);

        // Test 5: redirect with same-cycle rvalid and pop, FIFO holding one
        inst_ready = 1'b0; imem_gnt = 1'b1;
        cycle(1'b1, 1'b1);
        resp(32'h77777777, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        redirect = 1'b1; pc_in = 64'h80; inst_ready = 1'b1;
        resp(32'h88888888, 1'b1);
        cycle(1'b0, 1'b0);
        redirect = 1'b0; inst_ready = 1'b0;
        cycle(1'b1, 1'b1);
        imem_gnt = 1'b0;
        resp(32'h99999999, 1'b1);
        cycle(1'b0, 1'b0);
        inst_ready = 1'b1;
        cycle(1'b1, 1'b0);

        // Test 6: reset mid-WAIT, response arrives after reset
        imem_gnt = 1'b1;
        cycle(1'b1, 1'b1);
        imem_gnt = 1'b0; reset = 1'b1;
        cycle(1'b0, 1'b0);
        reset = 1'b0;
        resp(32'hBBBBBBBB, 1'b0);
        cycle(1'b1, 1'b0);
        #1;
        chk("post_rst_inst_out", inst_out, '0);
        chk("post_rst_inst_pc", inst_pc, '0);
        imem_gnt = 1'b1;
        cycle(1'b1, 1'b1);
        imem_gnt = 1'b0;
        resp(32'hCCCCCCCC, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
